// File: rtl/pipe_pkg.sv
// Shared encodings and defaults for the pipeline sequencing controller.
// Holds Tuse/Tnew codes, MDU latencies and the MDU tracker state type.
package pipe_pkg;

    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;
    localparam logic [1:0] TNEW_3 = 2'd3;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // A producer blocks a consumer when its value arrives after the consumer needs it.
    // Tuse of 3 never loses against a Tnew, so unused operands never stall.
    function automatic logic raw_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] wr,
        input logic [1:0] tnew,
        input logic       we
    );
        return (src != 5'd0) && we && (wr == src) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/mdu_busy_tracker.sv
// Multiply/divide busy window tracker: IDLE/BUSY FSM with a down-counter.
// md_done marks the last busy cycle, at whose end HI/LO are written.
module mdu_busy_tracker
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_start,
    input  logic             md_is_div,
    input  logic             req,
    output logic             md_busy,
    output logic [CNT_W-1:0] md_cnt,
    output logic             md_done
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    md_state_e        state;
    md_state_e        state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // A start alongside req belongs to an instruction younger than the
    // excepting one, so it never launches; req cannot abort a running op.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (md_start && !req) begin
                    state_n = BUSY;
                    cnt_n   = md_is_div ? DIV_LD : MULT_LD;
                end
            end
            BUSY: begin
                if (cnt == ONE) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign md_busy = (state == BUSY);
    assign md_cnt  = cnt;
    assign md_done = (state == BUSY) && (cnt == ONE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage MIPS pipeline.
// Combines RAW, MDU and ERET hazards; a CP0 request overrides all stalls.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [1:0]       tuse_rs_D,
    input  logic [1:0]       tuse_rt_D,
    input  logic [4:0]       WR_E,
    input  logic [4:0]       WR_M,
    input  logic [1:0]       tnew_E,
    input  logic [1:0]       tnew_M,
    input  logic             RegWrite_E,
    input  logic             RegWrite_M,
    input  logic             md_use_D,
    input  logic             md_start_E,
    input  logic             md_is_div_E,
    input  logic             eret_D,
    input  logic             w_cp0_epc_E,
    input  logic             w_cp0_epc_M,
    input  logic             req,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_E,
    output logic             md_busy,
    output logic [CNT_W-1:0] md_cnt,
    output logic             md_done
);

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall_eret;
    logic stall;

    mdu_busy_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_mdu (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start_E),
        .md_is_div (md_is_div_E),
        .req       (req),
        .md_busy   (md_busy),
        .md_cnt    (md_cnt),
        .md_done   (md_done)
    );

    assign stall_rs =
        raw_hazard(rs_D, tuse_rs_D, WR_E, tnew_E, RegWrite_E) ||
        raw_hazard(rs_D, tuse_rs_D, WR_M, tnew_M, RegWrite_M);

    assign stall_rt =
        raw_hazard(rt_D, tuse_rt_D, WR_E, tnew_E, RegWrite_E) ||
        raw_hazard(rt_D, tuse_rt_D, WR_M, tnew_M, RegWrite_M);

    // A start in E counts as busy so a back-to-back HI/LO user waits too.
    assign stall_md   = md_use_D && (md_busy || md_start_E);
    assign stall_eret = eret_D && (w_cp0_epc_E || w_cp0_epc_M);

    assign stall = stall_rs || stall_rt || stall_md || stall_eret;

    assign stall_F = stall && !req;
    assign stall_D = stall && !req;
    assign flush_E = stall && !req;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Inputs change 1 time unit after each rising edge; checks follow immediately.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] tuse_rs_D;
    logic [1:0] tuse_rt_D;
    logic [4:0] WR_E;
    logic [4:0] WR_M;
    logic [1:0] tnew_E;
    logic [1:0] tnew_M;
    logic       RegWrite_E;
    logic       RegWrite_M;
    logic       md_use_D;
    logic       md_start_E;
    logic       md_is_div_E;
    logic       eret_D;
    logic       w_cp0_epc_E;
    logic       w_cp0_epc_M;
    logic       req;
    logic       stall_F;
    logic       stall_D;
    logic       flush_E;
    logic       md_busy;
    logic [3:0] md_cnt;
    logic       md_done;

    int passed = 0;
    int total  = 0;

    pipe_hazard_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rs_D        (rs_D),
        .rt_D        (rt_D),
        .tuse_rs_D   (tuse_rs_D),
        .tuse_rt_D   (tuse_rt_D),
        .WR_E        (WR_E),
        .WR_M        (WR_M),
        .tnew_E      (tnew_E),
        .tnew_M      (tnew_M),
        .RegWrite_E  (RegWrite_E),
        .RegWrite_M  (RegWrite_M),
        .md_use_D    (md_use_D),
        .md_start_E  (md_start_E),
        .md_is_div_E (md_is_div_E),
        .eret_D      (eret_D),
        .w_cp0_epc_E (w_cp0_epc_E),
        .w_cp0_epc_M (w_cp0_epc_M),
        .req         (req),
        .stall_F     (stall_F),
        .stall_D     (stall_D),
        .flush_E     (flush_E),
        .md_busy     (md_busy),
        .md_cnt      (md_cnt),
        .md_done     (md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus must never start the MDU while it is busy.
    always @(posedge clk) begin
        if (reset && md_start_E && md_busy) begin
            total++;
            $error("FAIL md_start_while_busy obs=1 exp=0");
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk1({tag, "_F"}, stall_F, exp);
        chk1({tag, "_D"}, stall_D, exp);
        chk1({tag, "_E"}, flush_E, exp);
    endtask

    task automatic quiet();
        rs_D        = 5'd0;
        rt_D        = 5'd0;
        tuse_rs_D   = 2'd3;
        tuse_rt_D   = 2'd3;
        WR_E        = 5'd0;
        WR_M        = 5'd0;
        tnew_E      = 2'd0;
        tnew_M      = 2'd0;
        RegWrite_E  = 1'b0;
        RegWrite_M  = 1'b0;
        md_use_D    = 1'b0;
        md_start_E  = 1'b0;
        md_is_div_E = 1'b0;
        eret_D      = 1'b0;
        w_cp0_epc_E = 1'b0;
        w_cp0_epc_M = 1'b0;
        req         = 1'b0;
    endtask

    initial begin
        quiet();
        reset = 1'b0;
        #12;
        chk1("rst_busy", md_busy, 1'b0);
        chk4("rst_cnt", md_cnt, 4'd0);
        chk1("rst_done", md_done, 1'b0);
        chk_stall("rst_stall", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        cyc();

        // lw $2 in E, add using $2 in D
        rs_D       = 5'd2;
        tuse_rs_D  = 2'd1;
        WR_E       = 5'd2;
        RegWrite_E = 1'b1;
        tnew_E     = 2'd2;
        #1;
        chk_stall("lw_use_E", 1'b1);
        cyc();
        RegWrite_E = 1'b0;
        WR_E       = 5'd0;
        tnew_E     = 2'd0;
        WR_M       = 5'd2;
        RegWrite_M = 1'b1;
        tnew_M     = 2'd1;
        #1;
        chk_stall("lw_use_M", 1'b0);

        // rt with tuse 0 against M producer at tnew 1
        rs_D      = 5'd0;
        tuse_rs_D = 2'd3;
        rt_D      = 5'd3;
        tuse_rt_D = 2'd0;
        WR_M      = 5'd3;
        #1;
        chk_stall("rt_M", 1'b1);
        cyc();
        quiet();

        // $0 never stalls
        rs_D       = 5'd0;
        tuse_rs_D  = 2'd0;
        WR_E       = 5'd0;
        RegWrite_E = 1'b1;
        tnew_E     = 2'd2;
        #1;
        chk_stall("zero_reg", 1'b0);
        cyc();
        quiet();

        // div with mflo waiting in D
        md_start_E  = 1'b1;
        md_is_div_E = 1'b1;
        md_use_D    = 1'b1;
        #1;
        chk1("div_T_stall", stall_F, 1'b1);
        cyc();
        md_start_E  = 1'b0;
        md_is_div_E = 1'b0;
        #1;
        chk1("div_busy1", md_busy, 1'b1);
        chk4("div_cnt1", md_cnt, 4'd10);
        chk1("div_stall1", stall_D, 1'b1);
        chk1("div_done1", md_done, 1'b0);
        for (int k = 2; k <= 10; k++) begin
            cyc();
            chk4("div_cnt", md_cnt, 4'(11 - k));
            chk1("div_stall", flush_E, 1'b1);
            chk1("div_done", md_done, (k == 10));
        end
        cyc();
        chk1("div_rel_busy", md_busy, 1'b0);
        chk4("div_rel_cnt", md_cnt, 4'd0);
        chk_stall("div_rel", 1'b0);
        quiet();

        // start squashed by req
        md_start_E = 1'b1;
        req        = 1'b1;
        #1;
        chk_stall("sq_stall", 1'b0);
        cyc();
        quiet();
        #1;
        chk1("sq_busy", md_busy, 1'b0);

        // mult with req arriving during BUSY
        md_start_E = 1'b1;
        cyc();
        md_start_E = 1'b0;
        chk4("mul_cnt5", md_cnt, 4'd5);
        cyc();
        chk4("mul_cnt4", md_cnt, 4'd4);
        req      = 1'b1;
        md_use_D = 1'b1;
        #1;
        chk_stall("mul_req", 1'b0);
        cyc();
        chk4("mul_cnt3", md_cnt, 4'd3);
        chk1("mul_busy3", md_busy, 1'b1);
        req = 1'b0;
        #1;
        chk1("mul_stall3", stall_F, 1'b1);
        cyc();
        chk4("mul_cnt2", md_cnt, 4'd2);
        cyc();
        chk4("mul_cnt1", md_cnt, 4'd1);
        chk1("mul_done", md_done, 1'b1);
        cyc();
        chk1("mul_end", md_busy, 1'b0);
        chk1("mul_rel", stall_F, 1'b0);
        quiet();

        // eret behind an EPC write
        eret_D      = 1'b1;
        w_cp0_epc_M = 1'b1;
        #1;
        chk_stall("eret", 1'b1);
        req = 1'b1;
        #1;
        chk_stall("eret_req", 1'b0);
        cyc();
        quiet();

        // reset in the middle of a div
        md_start_E  = 1'b1;
        md_is_div_E = 1'b1;
        cyc();
        md_start_E  = 1'b0;
        md_is_div_E = 1'b0;
        cyc();
        cyc();
        chk4("rb_cnt3", md_cnt, 4'd8);
        #2;
        reset = 1'b0;
        #1;
        chk1("rb_busy", md_busy, 1'b0);
        chk4("rb_cnt", md_cnt, 4'd0);
        #1;
        reset = 1'b1;
        cyc();
        md_start_E = 1'b1;
        cyc();
        md_start_E = 1'b0;
        chk4("rm_cnt5", md_cnt, 4'd5);
        cyc();
        cyc();
        cyc();
        chk4("rm_cnt2", md_cnt, 4'd2);
        cyc();
        chk1("rm_done", md_done, 1'b1);
        cyc();
        chk1("rm_end", md_busy, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
